// File: rtl/npc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_gen_pkg
//  Description : Shared types and widths for the next-PC generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_gen_pkg;

    // Architectural register / address width of the core
    localparam int MXLEN = 32;

    // Next-PC generator control state
    typedef enum logic [0:0] {
        NPC_BOOT = 1'b0,
        NPC_RUN  = 1'b1
    } npc_state_e;

endpackage : npc_gen_pkg
`default_nettype wire

// File: rtl/npc_seq_inc.sv
`default_nettype none
// ============================================================================
//  Module      : npc_seq_inc
//  Description : Combinational sequential-fetch incrementer. Aligns the PC
//                down to the fetch block and steps to the next block, wrapping
//                modulo 2**MXLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_seq_inc
    import npc_gen_pkg::*;
#(
    parameter int FETCH_BYTES = 16
) (
    input  logic [MXLEN-1:0] i_pc,
    output logic [MXLEN-1:0] o_pc_nxt
);

    localparam logic [MXLEN-1:0] c_blk_bytes = MXLEN'(FETCH_BYTES);
    localparam logic [MXLEN-1:0] c_blk_mask  = ~(c_blk_bytes - MXLEN'(1));

    // A misaligned PC lands on the start of the following block
    assign o_pc_nxt = (i_pc & c_blk_mask) + c_blk_bytes;

endmodule : npc_seq_inc
`default_nettype wire

// File: rtl/npc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : npc_gen
//  Description : Next-PC generator at the head of the IFU. Holds the fetch PC,
//                issues one valid/ready request per cycle to IF0, follows
//                redirects with an epoch bump and a one-cycle flush pulse, and
//                counts accepted redirects (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_gen
    import npc_gen_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_VEC   = 32'h8000_0000,
    parameter int               FETCH_BYTES = 16,
    parameter int               EPOCH_W     = 2,
    parameter int               BOOT_CYC    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [MXLEN-1:0]   i_pcRedirect_npcGen_npc,
    input  logic               i_pcRedirect_npcGen_redirect_valid,
    input  logic               i_if0_npcGen_ready,
    output logic [MXLEN-1:0]   o_npcGen_if0_pc,
    output logic               o_npcGen_if0_valid,
    output logic [EPOCH_W-1:0] o_npcGen_if0_epoch,
    output logic               o_npcGen_flush,
    output logic [31:0]        o_npcGen_redirect_cnt
);

    localparam int                c_boot_w    = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [c_boot_w-1:0] c_boot_last = c_boot_w'(BOOT_CYC - 1);
    localparam logic [31:0]       c_cnt_max   = 32'hFFFF_FFFF;

    npc_state_e          r_state;
    npc_state_e          w_state_nxt;
    logic [c_boot_w-1:0] r_boot_cnt;
    logic [c_boot_w-1:0] w_boot_cnt_nxt;
    logic [MXLEN-1:0]    r_pc;
    logic [MXLEN-1:0]    w_pc_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic [EPOCH_W-1:0]  r_epoch;
    logic [EPOCH_W-1:0]  w_epoch_nxt;
    logic                r_flush;
    logic                w_flush_nxt;
    logic [31:0]         r_redir_cnt;
    logic [31:0]         w_redir_cnt_nxt;

    logic [MXLEN-1:0]    w_pc_seq;
    logic [MXLEN-1:0]    w_redir_pc;
    logic                w_redir;
    logic                w_boot_done;

    assign w_redir     = i_pcRedirect_npcGen_redirect_valid;
    // Redirect targets are forced to 2-byte alignment
    assign w_redir_pc  = i_pcRedirect_npcGen_npc & ~MXLEN'(1);
    assign w_boot_done = (r_boot_cnt == c_boot_last);

    npc_seq_inc #(
        .FETCH_BYTES (FETCH_BYTES)
    ) u_seq_inc (
        .i_pc     (r_pc),
        .o_pc_nxt (w_pc_seq)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= NPC_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave BOOT when the idle window ends or a redirect arrives
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NPC_BOOT: if (w_redir || w_boot_done) w_state_nxt = NPC_RUN;
            NPC_RUN:  w_state_nxt = NPC_RUN;
            default:  w_state_nxt = NPC_BOOT;
        endcase
    end

    // Next datapath values; redirect wins over boot timing and handshake
    always_comb begin
        w_pc_nxt        = r_pc;
        w_valid_nxt     = r_valid;
        w_epoch_nxt     = r_epoch;
        w_flush_nxt     = 1'b0;
        w_redir_cnt_nxt = r_redir_cnt;
        w_boot_cnt_nxt  = r_boot_cnt;
        if (w_redir) begin
            w_pc_nxt    = w_redir_pc;
            w_valid_nxt = 1'b1;
            w_epoch_nxt = r_epoch + EPOCH_W'(1);
            w_flush_nxt = 1'b1;
            if (r_redir_cnt != c_cnt_max) begin
                w_redir_cnt_nxt = r_redir_cnt + 32'd1;
            end
        end else begin
            case (r_state)
                NPC_BOOT: begin
                    if (w_boot_done) begin
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = RESET_VEC;
                    end else begin
                        w_boot_cnt_nxt = r_boot_cnt + c_boot_w'(1);
                    end
                end
                NPC_RUN: begin
                    // A stalled request (valid & !ready) holds everything
                    if (r_valid && i_if0_npcGen_ready) begin
                        w_pc_nxt = w_pc_seq;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and perf-counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_boot_cnt  <= '0;
            r_pc        <= RESET_VEC;
            r_valid     <= 1'b0;
            r_epoch     <= '0;
            r_flush     <= 1'b0;
            r_redir_cnt <= '0;
        end else begin
            r_boot_cnt  <= w_boot_cnt_nxt;
            r_pc        <= w_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_epoch     <= w_epoch_nxt;
            r_flush     <= w_flush_nxt;
            r_redir_cnt <= w_redir_cnt_nxt;
        end
    end

    assign o_npcGen_if0_pc       = r_pc;
    assign o_npcGen_if0_valid    = r_valid;
    assign o_npcGen_if0_epoch    = r_epoch;
    assign o_npcGen_flush        = r_flush;
    assign o_npcGen_redirect_cnt = r_redir_cnt;

endmodule : npc_gen
`default_nettype wire

// File: tb/tb_npc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_gen
//  Description : Scoreboard bench for npc_gen with a behavioural next-PC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_gen;

    localparam logic [31:0] RESET_VEC   = 32'h8000_0000;
    localparam int          FETCH_BYTES = 16;
    localparam int          EPOCH_W     = 2;
    localparam int          BOOT_CYC    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] redir_npc;
    logic        redir_valid;
    logic        ready;
    logic [31:0] pc;
    logic        valid;
    logic [EPOCH_W-1:0] epoch;
    logic        flush;
    logic [31:0] redir_cnt;

    npc_gen #(
        .RESET_VEC   (RESET_VEC),
        .FETCH_BYTES (FETCH_BYTES),
        .EPOCH_W     (EPOCH_W),
        .BOOT_CYC    (BOOT_CYC)
    ) dut (
        .i_clk                              (clk),
        .i_rst_n                            (rst_n),
        .i_pcRedirect_npcGen_npc            (redir_npc),
        .i_pcRedirect_npcGen_redirect_valid (redir_valid),
        .i_if0_npcGen_ready                 (ready),
        .o_npcGen_if0_pc                    (pc),
        .o_npcGen_if0_valid                 (valid),
        .o_npcGen_if0_epoch                 (epoch),
        .o_npcGen_flush                     (flush),
        .o_npcGen_redirect_cnt              (redir_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               v;
        logic [31:0]        pc;
        logic [EPOCH_W-1:0] ep;
        logic               fl;
        logic [31:0]        cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model state (what the outputs should show after the next edge)
    bit     m_run;
    int     m_boot_edges;
    longint m_pc;
    bit     m_v;
    int     m_ep;
    bit     m_fl;
    longint m_cnt;

    task automatic model_reset();
        m_run = 0; m_boot_edges = 0; m_pc = RESET_VEC;
        m_v = 0; m_ep = 0; m_fl = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit rd, input logic [31:0] tgt, input bit rdy);
        longint t;
        obs_t   o;
        t = tgt;
        if (rd) begin
            m_pc  = t - (t % 2);
            m_v   = 1;
            m_ep  = (m_ep + 1) % (1 << EPOCH_W);
            m_fl  = 1;
            m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
            m_run = 1;
        end else if (!m_run) begin
            m_fl = 0;
            m_boot_edges++;
            if (m_boot_edges == BOOT_CYC) begin
                m_run = 1; m_v = 1; m_pc = RESET_VEC;
            end
        end else begin
            m_fl = 0;
            if (m_v && rdy)
                m_pc = ((m_pc / FETCH_BYTES) * FETCH_BYTES + FETCH_BYTES) % 64'h1_0000_0000;
        end
        o.v = m_v; o.pc = m_pc[31:0]; o.ep = m_ep[EPOCH_W-1:0];
        o.fl = m_fl; o.cnt = m_cnt[31:0];
        exp_q.push_back(o);
    endtask

    // Drive one cycle of stimulus (called at a falling edge), then wait a cycle
    task automatic cyc(input bit rd, input logic [31:0] tgt, input bit rdy);
        redir_valid = rd;
        redir_npc   = tgt;
        ready       = rdy;
        model_step(rd, tgt, rdy);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must return at once
    task automatic do_reset();
        #2 rst_n = 1'b0;
        redir_valid = 1'b0;
        ready = 1'b0;
        #1;
        n_checks++;
        if (valid === 1'b0 && pc === RESET_VEC && epoch === '0 && flush === 1'b0 && redir_cnt === 32'd0)
            n_pass++;
        else
            $display("FAIL async_reset t=%0t act v=%b pc=%h ep=%0d fl=%b cnt=%0d exp v=0 pc=%h ep=0 fl=0 cnt=0",
                     $time, valid, pc, epoch, flush, redir_cnt, RESET_VEC);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one expected observation per clock edge
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (valid === e.v && pc === e.pc && epoch === e.ep && flush === e.fl && redir_cnt === e.cnt)
                n_pass++;
            else
                $display("FAIL cycle_out t=%0t act v=%b pc=%h ep=%0d fl=%b cnt=%0d exp v=%b pc=%h ep=%0d fl=%b cnt=%0d",
                         $time, valid, pc, epoch, flush, redir_cnt, e.v, e.pc, e.ep, e.fl, e.cnt);
        end
    end

    initial begin
        rst_n = 1'b0; redir_valid = 1'b0; redir_npc = '0; ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (valid === 1'b0 && pc === RESET_VEC && epoch === '0 && flush === 1'b0 && redir_cnt === 32'd0)
            n_pass++;
        else
            $display("FAIL reset_state act v=%b pc=%h ep=%0d fl=%b cnt=%0d", valid, pc, epoch, flush, redir_cnt);
        rst_n = 1'b1;

        // Boot and sequential fetch
        repeat (5) cyc(0, '0, 1);
        // Stall then resume
        repeat (3) cyc(0, '0, 0);
        cyc(0, '0, 1);
        // Redirect during a stall, then sequential
        cyc(0, '0, 0);
        cyc(1, 32'h0000_1236, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        // Back-to-back redirects, epoch wraps
        cyc(1, 32'h0000_0100, 1);
        cyc(1, 32'h0000_0204, 0);
        cyc(1, 32'h0000_03F0, 1);
        cyc(0, '0, 1);
        // Odd target and wrap at the top of the address space
        cyc(1, 32'h0000_2001, 1);
        cyc(0, '0, 1);
        cyc(1, 32'hFFFF_FFF0, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        cyc(1, 32'hFFFF_FFF7, 1);
        cyc(0, '0, 1);
        // Reset mid-stall, redirect during BOOT
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        do_reset();
        cyc(1, 32'h0000_4000, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        do_reset();
        cyc(0, '0, 1);
        cyc(1, 32'h1234_5679, 1);
        cyc(0, '0, 1);

        // Randomised traffic with an occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            bit          rd;
            rd = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            else
                t = $urandom;
            cyc(rd, t, ($urandom_range(0, 9) < 7));
            if (i % 150 == 149) do_reset();
        end

        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain act pending=%0d exp pending=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_npc_gen
`default_nettype wire
